// File: rtl/boxhead_pkg.sv
// rtl/boxhead_pkg.sv - shared health types, widths and saturation helper
package boxhead_pkg;

    localparam int BLOOD_W = 10;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } health_state_t;

    // Clamp an 11-bit sum back into the 0..max blood range.
    function automatic logic [BLOOD_W-1:0] sat_blood(input logic [BLOOD_W:0] sum,
                                                     input logic [BLOOD_W-1:0] max);
        return (sum > {1'b0, max}) ? max : sum[BLOOD_W-1:0];
    endfunction

endpackage

// File: rtl/player_health_if.sv
// rtl/player_health_if.sv - damage and heal request/ack channels
interface player_health_if;
    import boxhead_pkg::*;

    logic               Damage_Req;
    logic [BLOOD_W-1:0] Damage_Amt;
    logic               Damage_Ack;
    logic               Heal_Req;
    logic [BLOOD_W-1:0] Heal_Amt;
    logic               Heal_Ack;

    modport master (
        output Damage_Req, Damage_Amt, Heal_Req, Heal_Amt,
        input  Damage_Ack, Heal_Ack
    );

    modport slave (
        input  Damage_Req, Damage_Amt, Heal_Req, Heal_Amt,
        output Damage_Ack, Heal_Ack
    );

endinterface

// File: rtl/health_timer.sv
// rtl/health_timer.sv - loadable frame counter, counting down or up on each tick
module health_timer
    import boxhead_pkg::*;
#(
    parameter bit UP = 1'b0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             tick,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (tick) begin
            if (UP)
                count <= count + CNT_W'(1);
            else if (count != '0)
                count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/player_health.sv
// rtl/player_health.sv - player health FSM; optional regen under macro BLOOD_REGEN_EN
module player_health
    import boxhead_pkg::*;
#(
    parameter int MAX_BLOOD     = 100,
    parameter int INVULN_FRAMES = 30,
    parameter int REGEN_PERIOD  = 60,
    parameter int REGEN_AMT     = 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Frame_Tick,
    input  logic               Restart,
    player_health_if.slave     bus,
    output logic [BLOOD_W-1:0] Player_Blood,
    output logic               Is_Dead,
    output logic               Invuln
);

    localparam logic [BLOOD_W-1:0] MAX_B = BLOOD_W'(MAX_BLOOD);

    health_state_t      state;
    logic [BLOOD_W-1:0] blood;
    logic               damage_ack;
    logic               heal_ack;
    logic               is_dead;
    logic               invuln;

    logic               dmg_acc;
    logic               heal_acc;
    logic               dmg_nonzero;
    logic               dmg_hit;
    logic               dies;
    logic               heal_ok;
    logic [BLOOD_W-1:0] dmg_blood;
    logic [BLOOD_W-1:0] base_blood;
    logic [BLOOD_W-1:0] healed;
    logic [BLOOD_W-1:0] next_blood;
    logic [CNT_W-1:0]   imm_count;
    logic               imm_done;

    assign Player_Blood   = blood;
    assign Is_Dead        = is_dead;
    assign Invuln         = invuln;
    assign bus.Damage_Ack = damage_ack;
    assign bus.Heal_Ack   = heal_ack;

    // A request is only new while its ack is low, so each one is acked once.
    assign dmg_acc     = bus.Damage_Req && !damage_ack;
    assign heal_acc    = bus.Heal_Req && !heal_ack;
    assign dmg_nonzero = dmg_acc && (bus.Damage_Amt != '0);
    assign dmg_hit     = dmg_nonzero && (state == ALIVE);
    assign dmg_blood   = (blood > bus.Damage_Amt) ? blood - bus.Damage_Amt : '0;
    assign base_blood  = dmg_hit ? dmg_blood : blood;
    assign dies        = dmg_hit && (dmg_blood == '0);
    assign heal_ok     = heal_acc && (state != DEAD) && !dies;
    assign healed      = sat_blood({1'b0, base_blood} +
                                   (heal_ok ? {1'b0, bus.Heal_Amt} : '0), MAX_B);
    assign imm_done    = (state == INVULN) && Frame_Tick && (imm_count <= CNT_W'(1));

    health_timer #(.UP(1'b0)) u_imm_timer (
        .clk        (Clk),
        .resetn     (Reset),
        .tick       (Frame_Tick && (state == INVULN)),
        .clear      (Restart),
        .load       (dmg_hit && !dies && !Restart),
        .load_value (CNT_W'(INVULN_FRAMES)),
        .count      (imm_count)
    );

`ifdef BLOOD_REGEN_EN
    logic [CNT_W-1:0] regen_count;
    logic             regen_tick;
    logic             regen_step;

    assign regen_tick = Frame_Tick && (state == ALIVE) && (blood < MAX_B);
    assign regen_step = regen_tick && !dmg_nonzero && !Restart &&
                        (regen_count == CNT_W'(REGEN_PERIOD - 1));
    // Heal and regen land in the same cycle; both are summed before saturating.
    assign next_blood = sat_blood({1'b0, healed} +
                                  (regen_step ? (BLOOD_W + 1)'(REGEN_AMT) : '0), MAX_B);

    health_timer #(.UP(1'b1)) u_regen_timer (
        .clk        (Clk),
        .resetn     (Reset),
        .tick       (regen_tick),
        .clear      (Restart || dmg_nonzero || regen_step ||
                     (state != ALIVE) || (blood == MAX_B)),
        .load       (1'b0),
        .load_value ('0),
        .count      (regen_count)
    );
`else
    assign next_blood = healed;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state      <= ALIVE;
            blood      <= MAX_B;
            damage_ack <= 1'b0;
            heal_ack   <= 1'b0;
            is_dead    <= 1'b0;
            invuln     <= 1'b0;
        end else begin
            damage_ack <= dmg_acc;
            heal_ack   <= heal_acc;
            if (Restart) begin
                state   <= ALIVE;
                blood   <= MAX_B;
                is_dead <= 1'b0;
                invuln  <= 1'b0;
            end else begin
                blood <= next_blood;
                case (state)
                    ALIVE: begin
                        if (dies) begin
                            state   <= DEAD;
                            is_dead <= 1'b1;
                        end else if (dmg_hit) begin
                            state  <= INVULN;
                            invuln <= 1'b1;
                        end
                    end
                    INVULN: begin
                        if (imm_done) begin
                            state  <= ALIVE;
                            invuln <= 1'b0;
                        end
                    end
                    DEAD:    state <= DEAD;
                    default: state <= ALIVE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_player_health.sv
// tb/tb_player_health.sv - self-checking bench for player_health with a behavioural model
module tb_player_health;
    import boxhead_pkg::*;

    localparam int MAX = 100;
    localparam int INV = 30;
    localparam int RP  = 60;
    localparam int RA  = 1;

    logic               Clk = 1'b0;
    logic               Reset = 1'b0;
    logic               Frame_Tick = 1'b0;
    logic               Restart = 1'b0;
    logic [BLOOD_W-1:0] Player_Blood;
    logic               Is_Dead;
    logic               Invuln;

    player_health_if bus();

    player_health #(
        .MAX_BLOOD     (MAX),
        .INVULN_FRAMES (INV),
        .REGEN_PERIOD  (RP),
        .REGEN_AMT     (RA)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Frame_Tick   (Frame_Tick),
        .Restart      (Restart),
        .bus          (bus),
        .Player_Blood (Player_Blood),
        .Is_Dead      (Is_Dead),
        .Invuln       (Invuln)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Model: mode 0 alive, 1 immune, 2 dead; frames and regen ticks as plain counts.
    int m_blood = MAX;
    int m_mode  = 0;
    int m_imm   = 0;
    int m_regen = 0;
    bit m_dack  = 0;
    bit m_hack  = 0;
    bit model_on = 0;

    always @(posedge Clk) begin
        bit da, ha;
        int damt, hamt, nb, nm;
        da   = bus.Damage_Req && !m_dack;
        ha   = bus.Heal_Req && !m_hack;
        damt = int'(bus.Damage_Amt);
        hamt = int'(bus.Heal_Amt);
        if (!Reset) begin
            m_blood = MAX; m_mode = 0; m_imm = 0; m_regen = 0;
            m_dack = 0; m_hack = 0; model_on = 1;
        end else begin
            m_dack = da;
            m_hack = ha;
            if (Restart) begin
                m_blood = MAX; m_mode = 0; m_imm = 0; m_regen = 0;
            end else begin
                nb = m_blood;
                nm = m_mode;
                if (m_mode == 1 && Frame_Tick) begin
                    m_imm = m_imm - 1;
                    if (m_imm == 0) nm = 0;
                end
                if (da && m_mode == 0 && damt > 0) begin
                    nb = m_blood - damt;
                    if (nb <= 0) begin nb = 0; nm = 2; end
                    else begin nm = 1; m_imm = INV; end
                end
                if (ha && m_mode != 2 && nm != 2)
                    nb = (nb + hamt > MAX) ? MAX : nb + hamt;
`ifdef BLOOD_REGEN_EN
                if (m_mode != 0 || m_blood == MAX || (da && damt > 0)) begin
                    m_regen = 0;
                end else if (Frame_Tick) begin
                    m_regen = m_regen + 1;
                    if (m_regen == RP) begin
                        m_regen = 0;
                        nb = (nb + RA > MAX) ? MAX : nb + RA;
                    end
                end
`endif
                m_blood = nb;
                m_mode  = nm;
            end
        end
    end

    always @(negedge Clk) begin
        if (model_on) begin
            check("blood",      32'(Player_Blood),   32'(m_blood));
            check("is_dead",    32'(Is_Dead),        32'(m_mode == 2));
            check("invuln",     32'(Invuln),         32'(m_mode == 1));
            check("damage_ack", 32'(bus.Damage_Ack), 32'(m_dack));
            check("heal_ack",   32'(bus.Heal_Ack),   32'(m_hack));
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic damage(input int a);
        bus.Damage_Amt = BLOOD_W'(a);
        bus.Damage_Req = 1'b1;
        step();
        bus.Damage_Req = 1'b0;
    endtask

    task automatic heal(input int a);
        bus.Heal_Amt = BLOOD_W'(a);
        bus.Heal_Req = 1'b1;
        step();
        bus.Heal_Req = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            Frame_Tick = 1'b1;
            step();
            Frame_Tick = 1'b0;
            step();
        end
    endtask

    initial begin
        int n;
        bus.Damage_Req = 1'b0;
        bus.Damage_Amt = '0;
        bus.Heal_Req   = 1'b0;
        bus.Heal_Amt   = '0;
        repeat (3) step();
        check("rst_blood",   32'(Player_Blood),   32'd100);
        check("rst_dead",    32'(Is_Dead),        32'd0);
        check("rst_invuln",  32'(Invuln),         32'd0);
        check("rst_dack",    32'(bus.Damage_Ack), 32'd0);
        check("rst_hack",    32'(bus.Heal_Ack),   32'd0);
        Reset = 1'b1;
        step();

        damage(25);
        check("d25_ack",    32'(bus.Damage_Ack), 32'd1);
        check("d25_blood",  32'(Player_Blood),   32'd75);
        check("d25_invuln", 32'(Invuln),         32'd1);
        step();
        damage(40);
        check("imm_ack",   32'(bus.Damage_Ack), 32'd1);
        check("imm_blood", 32'(Player_Blood),   32'd75);
        ticks(29);
        check("tick29_invuln", 32'(Invuln), 32'd1);
        ticks(1);
        check("tick30_invuln", 32'(Invuln), 32'd0);

        damage(65);
        check("d65_blood", 32'(Player_Blood), 32'd10);
        ticks(30);
        bus.Damage_Amt = BLOOD_W'(40); bus.Damage_Req = 1'b1;
        bus.Heal_Amt   = BLOOD_W'(50); bus.Heal_Req   = 1'b1;
        step();
        bus.Damage_Req = 1'b0; bus.Heal_Req = 1'b0;
        check("both_dack",  32'(bus.Damage_Ack), 32'd1);
        check("both_hack",  32'(bus.Heal_Ack),   32'd1);
        check("both_blood", 32'(Player_Blood),   32'd0);
        check("both_dead",  32'(Is_Dead),        32'd1);
        step();
        heal(30);
        check("dead_heal_ack",   32'(bus.Heal_Ack), 32'd1);
        check("dead_heal_blood", 32'(Player_Blood), 32'd0);
        Restart = 1'b1;
        step();
        Restart = 1'b0;
        check("restart_blood", 32'(Player_Blood), 32'd100);
        check("restart_dead",  32'(Is_Dead),      32'd0);

        damage(5);
        check("d5_blood", 32'(Player_Blood), 32'd95);
        step();
        heal(20);
        check("heal_sat", 32'(Player_Blood), 32'd100);
        step();
        bus.Heal_Amt = BLOOD_W'(5);
        bus.Heal_Req = 1'b1;
        n = 0;
        repeat (2) begin step(); if (bus.Heal_Ack) n++; end
        bus.Heal_Req = 1'b0;
        repeat (3) begin step(); if (bus.Heal_Ack) n++; end
        check("held_heal_pulses", 32'(n), 32'd1);

        ticks(30);
        damage(0);
        check("d0_ack",    32'(bus.Damage_Ack), 32'd1);
        check("d0_blood",  32'(Player_Blood),   32'd100);
        check("d0_invuln", 32'(Invuln),         32'd0);
        step();
        damage(1000);
        check("big_blood", 32'(Player_Blood), 32'd0);
        check("big_dead",  32'(Is_Dead),      32'd1);
        step();
        damage(7);
        check("dead_dmg_ack", 32'(bus.Damage_Ack), 32'd1);
        step();
        bus.Damage_Amt = BLOOD_W'(9); bus.Damage_Req = 1'b1;
        Restart = 1'b1;
        step();
        bus.Damage_Req = 1'b0; Restart = 1'b0;
        check("rs_dmg_ack", 32'(bus.Damage_Ack), 32'd1);
        check("rs_blood",   32'(Player_Blood),   32'd100);
        check("rs_invuln",  32'(Invuln),         32'd0);
        step();

        bus.Damage_Amt = BLOOD_W'(50); bus.Damage_Req = 1'b1;
        Reset = 1'b0;
        step();
        check("rstmid_ack", 32'(bus.Damage_Ack), 32'd0);
        step();
        bus.Damage_Req = 1'b0;
        Reset = 1'b1;
        step();
        check("rstmid_ack2",  32'(bus.Damage_Ack), 32'd0);
        check("rstmid_blood", 32'(Player_Blood),   32'd100);

`ifdef BLOOD_REGEN_EN
        damage(10);
        ticks(30);
        ticks(59);
        check("regen59", 32'(Player_Blood), 32'd90);
        damage(0);
        ticks(1);
        check("regen60", 32'(Player_Blood), 32'd91);
        ticks(20);
        damage(1);
        check("regen_d1", 32'(Player_Blood), 32'd90);
        ticks(30);
        ticks(59);
        check("regen_restart", 32'(Player_Blood), 32'd90);
        ticks(1);
        check("regen_step2", 32'(Player_Blood), 32'd91);
`endif

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
